// File: rtl/lsu_byte_streamer_if.sv
// lsu_byte_streamer_if: word-in / byte-out handshake bundle for the LSU byte streamer.
//   word side : word_valid, word_ready, word_data[31:0], byte_mask[3:0]
//   byte side : byte_valid, byte_ready, byte_data[7:0], byte_idx[1:0], byte_last
//   status    : done (one-cycle pulse after each completed word)
//   slave = the streamer, master = the producer/consumer pair driving it
interface lsu_byte_streamer_if;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [3:0]  byte_mask;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic [1:0]  byte_idx;
    logic        byte_last;
    logic        done;

    modport slave (
        input  word_valid, word_data, byte_mask, byte_ready,
        output word_ready, byte_valid, byte_data, byte_idx, byte_last, done
    );

    modport master (
        output word_valid, word_data, byte_mask, byte_ready,
        input  word_ready, byte_valid, byte_data, byte_idx, byte_last, done
    );
endinterface

// File: rtl/lsu_byte_streamer.sv
// lsu_byte_streamer: serializes the enabled byte lanes of a 32-bit store word onto a byte handshake.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous abort of the word in flight (no done)
//   bus     : lsu_byte_streamer_if.slave (word accept side, byte emit side, done pulse)
//   MSB_FIRST = 0 emits lanes 0->3, 1 emits lanes 3->0
module lsu_byte_streamer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    lsu_byte_streamer_if.slave   bus
);
    typedef enum logic {IDLE, SEND} state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  rem_q, rem_d, rem_nx;
    logic [1:0]  cur_q, cur_d;
    logic        done_q, done_d;
    logic        ready, xfer, last, acc;

    function automatic logic [1:0] first(input logic [3:0] m);
        if (MSB_FIRST) return m[3] ? 2'd3 : m[2] ? 2'd2 : m[1] ? 2'd1 : 2'd0;
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    assign bus.byte_valid = state_q == SEND;
    assign bus.byte_idx   = cur_q;
    assign bus.byte_data  = hold_q[8*cur_q +: 8];
    // rem always holds the not-yet-sent lanes including cur, so one bit left means final byte
    assign bus.byte_last  = $onehot(rem_q);
    assign bus.done       = done_q;
    assign bus.word_ready = ready;

    assign xfer   = bus.byte_valid & bus.byte_ready;
    assign last   = xfer & bus.byte_last;
    // rst_ni gates ready so nothing looks acceptable while reset is held
    assign ready  = rst_ni & !flush_i & (state_q == IDLE | last);
    assign acc    = bus.word_valid & ready;
    assign rem_nx = rem_q & ~(4'b0001 << cur_q);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rem_d   = rem_q;
        cur_d   = cur_q;
        done_d  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (acc) begin
            hold_d  = bus.word_data;
            rem_d   = bus.byte_mask;
            cur_d   = first(bus.byte_mask);
            state_d = |bus.byte_mask ? SEND : IDLE;
            // a finishing word and a zero-mask word both complete on this edge
            done_d  = last | ~|bus.byte_mask;
        end else if (xfer) begin
            rem_d   = rem_nx;
            cur_d   = first(rem_nx);
            state_d = last ? IDLE : SEND;
            done_d  = last;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rem_q   <= '0;
            cur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_lsu_byte_streamer.sv
// tb_lsu_byte_streamer: directed vector bench for lsu_byte_streamer (LSB-first and MSB-first instances).
module tb_lsu_byte_streamer;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_byte_streamer_if ifa ();
    lsu_byte_streamer_if ifb ();

    lsu_byte_streamer #(.MSB_FIRST(1'b0)) dut_a (.clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .bus(ifa.slave));
    lsu_byte_streamer #(.MSB_FIRST(1'b1)) dut_b (.clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .bus(ifb.slave));

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  m;
        logic        br;
        logic        fl;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ei;
        logic        el;
        logic        edn;
        logic        ewr;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    function automatic vec_t v(input logic wv, input logic [31:0] wd, input logic [3:0] m, input logic br,
                               input logic fl, input logic ev, input logic [7:0] ed, input logic [1:0] ei,
                               input logic el, input logic edn, input logic ewr);
        vec_t t;
        t.wv = wv; t.wd = wd; t.m = m; t.br = br; t.fl = fl;
        t.ev = ev; t.ed = ed; t.ei = ei; t.el = el; t.edn = edn; t.ewr = ewr;
        return t;
    endfunction

    task automatic drive(input logic wv, input logic [31:0] wd, input logic [3:0] m, input logic br, input logic fl);
        ifa.word_valid = wv; ifa.word_data = wd; ifa.byte_mask = m; ifa.byte_ready = br;
        ifb.word_valid = wv; ifb.word_data = wd; ifb.byte_mask = m; ifb.byte_ready = br;
        flush = fl;
    endtask

    // got/exp layout: {valid, data[7:0], idx[1:0], last, done, word_ready}
    task automatic cmp(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got v=%b d=%h i=%0d l=%b dn=%b wr=%b, exp v=%b d=%h i=%0d l=%b dn=%b wr=%b",
                     name, got[13], got[12:5], got[4:3], got[2], got[1], got[0],
                     exp[13], exp[12:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [13:0] outs(input bit sel);
        return sel ? {ifb.byte_valid, ifb.byte_data, ifb.byte_idx, ifb.byte_last, ifb.done, ifb.word_ready}
                   : {ifa.byte_valid, ifa.byte_data, ifa.byte_idx, ifa.byte_last, ifa.done, ifa.word_ready};
    endfunction

    // data/idx are only meaningful while byte_valid is expected high
    task automatic apply(input vec_t t, input bit sel, input string name);
        logic [13:0] g, e;
        @(negedge clk);
        drive(t.wv, t.wd, t.m, t.br, t.fl);
        #1;
        g = outs(sel);
        e = {t.ev, t.ed, t.ei, t.el, t.edn, t.ewr};
        if (!t.ev) begin
            g[12:3] = '0;
            e[12:3] = '0;
        end
        cmp(name, g, e);
    endtask

    initial begin
        drive(1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
        #1;
        cmp("reset_init_a", outs(1'b0), 14'd0);
        cmp("reset_init_b", outs(1'b1), 14'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        rst_ni = 1'b1;

        //           wv  wd            m     br  fl  ev  ed     ei    el  dn  wr
        va.push_back(v(1, 32'hDDCCBBAA, 4'hF, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hAA, 2'd0, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hBB, 2'd1, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hCC, 2'd2, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hDD, 2'd3, 1, 0, 1));
        va.push_back(v(1, 32'h12121212, 4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 1, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 1, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(1, 32'hA1B2C3D4, 4'hD, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hD4, 2'd0, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 0, 0, 1, 8'hB2, 2'd2, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 0, 0, 1, 8'hB2, 2'd2, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hB2, 2'd2, 0, 0, 0));
        va.push_back(v(1, 32'h0000EEFF, 4'h3, 0, 0, 1, 8'hA1, 2'd3, 1, 0, 0));
        va.push_back(v(1, 32'h0000EEFF, 4'h3, 1, 0, 1, 8'hA1, 2'd3, 1, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hFF, 2'd0, 0, 1, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hEE, 2'd1, 1, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 1, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(1, 32'hCAFEF00D, 4'hF, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'h0D, 2'd0, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hF0, 2'd1, 0, 0, 0));
        va.push_back(v(1, 32'h99999999, 4'hF, 1, 1, 1, 8'hFE, 2'd2, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(1, 32'h12345678, 4'hF, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'h78, 2'd0, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'h56, 2'd1, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'h34, 2'd2, 0, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'h12, 2'd3, 1, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 1, 1));
        va.push_back(v(1, 32'h000000AB, 4'h1, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(1, 32'h55555555, 4'hF, 1, 1, 1, 8'hAB, 2'd0, 1, 0, 0));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        va.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));

        vb.push_back(v(1, 32'h44332211, 4'hA, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'h44, 2'd3, 0, 0, 0));
        vb.push_back(v(1, 32'hDDCCBBAA, 4'hF, 1, 0, 1, 8'h22, 2'd1, 1, 0, 1));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hDD, 2'd3, 0, 1, 0));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hCC, 2'd2, 0, 0, 0));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hBB, 2'd1, 0, 0, 0));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hAA, 2'd0, 1, 0, 1));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 1, 1));
        vb.push_back(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1));

        foreach (va[i]) apply(va[i], 1'b0, $sformatf("lsb_row%0d", i));
        foreach (vb[i]) apply(vb[i], 1'b1, $sformatf("msb_row%0d", i));

        apply(v(1, 32'h87654321, 4'hF, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1), 1'b0, "rst_seq_accept");
        apply(v(1, 32'h11111111, 4'hF, 1, 0, 1, 8'h21, 2'd0, 0, 0, 0), 1'b0, "rst_seq_byte0");
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        cmp("rst_async_a", outs(1'b0), 14'd0);
        cmp("rst_async_b", outs(1'b1), 14'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        rst_ni = 1'b1;
        #1;
        cmp("rst_release", outs(1'b0), 14'b0_00000000_00_0_0_1);
        for (int i = 0; i < 3; i++)
            apply(v(0, 32'h0, 4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1), 1'b0, $sformatf("rst_quiet%0d", i));
        apply(v(1, 32'h0000BE00, 4'h2, 1, 0, 0, 8'h00, 2'd0, 0, 0, 1), 1'b0, "rst_new_accept");
        apply(v(0, 32'h0,        4'h0, 1, 0, 1, 8'hBE, 2'd1, 1, 0, 1), 1'b0, "rst_new_byte");
        apply(v(0, 32'h0,        4'h0, 1, 0, 0, 8'h00, 2'd0, 0, 1, 1), 1'b0, "rst_new_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_byte_streamer.md
# lsu_byte_streamer

Store-side byte serializer for the LSU. It accepts a 32-bit store word and a 4-bit byte-lane mask, then emits the enabled bytes one per handshake on an 8-bit valid/ready port. Byte-wide consumers (UART TX, byte-wide scratch/peripheral buses) sit on that port. It is the opposite direction of the LSU byte/word register, which assembles bytes into a word.

## Interface
Parameters:
- MSB_FIRST, default 0: 0 sends lanes in the order 0→3; 1 sends them 3→0.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous abort of the word in flight.
- word_valid, input, 1: a store word is offered.
- word_ready, output, 1: the block can accept a word this cycle.
- word_data, input, 32: store data; lane i is word_data[8i+7:8i].
- byte_mask, input, 4: lane enables; bit i enables lane i.
- byte_valid, output, 1: byte_data, byte_idx and byte_last are valid.
- byte_ready, input, 1: the consumer takes the byte.
- byte_data, output, 8: current lane byte.
- byte_idx, output, 2: lane number of the current byte.
- byte_last, output, 1: the current byte is the final enabled lane of the word.
- done, output, 1: one-cycle pulse, one cycle after a word completes.

## Operation
- Two states: IDLE and SEND.
- Word accept: a word is accepted on a clock edge where word_valid & word_ready.
  - word_ready = !flush & (IDLE | (SEND & byte_valid & byte_ready & byte_last)).
  - On accept, word_data goes into the hold register and byte_mask goes into the remaining-mask register rem.
- Accept with byte_mask ≠ 0:
  - The state becomes SEND.
  - cur = the first set bit of rem in the configured order.
- Accept with byte_mask = 0:
  - The state stays or becomes IDLE. No byte is emitted.
  - done pulses on the next cycle.
- Outputs in SEND:
  - byte_valid = 1.
  - byte_idx = cur; byte_data = hold[8*cur +: 8].
  - byte_last = 1 when rem has exactly one bit set.
- Transfer: a byte transfers on an edge where byte_valid & byte_ready. On each transfer:
  - Clear rem[cur].
  - cur moves to the next set bit in order. Unset lanes are skipped with no bubble cycles.
- Last byte:
  - A last-byte transfer with no simultaneous accept returns the block to IDLE.
  - If a new word is accepted on that same edge, the block stays in SEND with the new word. byte_valid stays high continuously.
- done rules:
  - A registered done pulse follows every completed word, including zero-mask words.
  - A back-to-back accept does not suppress done.
- Stall: while byte_ready = 0, byte_data, byte_idx and byte_last hold stable.
- flush:
  - Force IDLE and clear rem.
  - byte_valid is low the next cycle. No done is generated.
  - flush overrides a same-cycle last-byte transfer: the byte counts as taken, but no done.
  - A word_valid in the flush cycle is not accepted.
- Reset (rst = 0, asynchronous): all outputs go to 0.
  - byte_valid = 0, byte_data = 0, byte_idx = 0, byte_last = 0, done = 0.
  - word_ready = 0 while rst is low; it is 1 in IDLE after release.
  - The hold register, rem and cur are cleared. A word in flight mid-operation is discarded with no done.
- All outputs except word_ready come from registers. word_ready is combinational from state, the handshake signals and flush.

## Timing
- Accept at edge N: the first byte is valid in cycle N+1.
- A k-lane word with byte_ready held high takes k cycles of byte_valid. done is high in the cycle after the last transfer.
- Throughput: one byte per cycle. Back-to-back words produce no idle cycle between them.
- Zero-mask word accepted at edge N: done is high in cycle N+1. word_ready stays high.
- byte_ready low for m cycles stretches the word by exactly m cycles.

## Test plan
- Basic order:
  - Stimulus: word_data=0xDDCCBBAA, mask=4'b1111, MSB_FIRST=0, byte_ready=1.
  - Required: bytes AA, BB, CC, DD with idx 0,1,2,3. byte_last only on DD. done one cycle after DD.
- Sparse mask and reversed order:
  - Stimulus: mask=4'b1010, word 0x44332211, MSB_FIRST=1.
  - Required: bytes 44 (idx 3), then 22 (idx 1, last), in consecutive cycles. No bubble.
- Back-to-back with backpressure:
  - Stimulus: a second word 0x0000EEFF, mask 4'b0011, is offered during the final byte of the first word. byte_ready is low for 2 cycles mid-word.
  - Required: the second word is accepted on the last-byte edge and FF follows immediately. Outputs hold stable during the stall. Two done pulses.
- Zero mask:
  - Stimulus: word accepted with mask=0.
  - Required: no byte_valid. done pulses the next cycle. word_ready stays 1.
- Flush mid-word:
  - Stimulus: mask=4'b1111; assert flush after byte 1 transfers.
  - Required: byte_valid is 0 the next cycle and no done. A following word 0x12345678 starts cleanly with byte 78.
- Async reset mid-word:
  - Stimulus: drop rst between clock edges during SEND.
  - Required: all outputs are 0 immediately. After release, word_ready=1 and no stale bytes appear.
